// File: rtl/ahb_write_slave.sv
// AHB-Lite byte-write slave for the err_status/payload_0/payload_1/data_size register file.
// Define AHB_WRITE_W1C_EN to make haddr==0 writable (W1C on err_status); otherwise such writes return ERROR.
module ahb_write_slave #(
  parameter logic [4:0] DATA_SIZE_MAX = 5'd16
) (
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       hsel_x,
  input  logic       hready,
  input  logic       hwrite,
  input  logic [1:0] htrans,
  input  logic [2:0] hsize,
  input  logic [1:0] haddr,
  input  logic [7:0] hwdata,
  input  logic [1:0] err_set,
  output logic       hready_out,
  output logic       hresp,
  output logic [1:0] err_status,
  output logic [7:0] payload_0,
  output logic [7:0] payload_1,
  output logic [4:0] data_size,
  output logic       wr_pulse,
  output logic [1:0] wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] addr_q;
  logic [2:0] size_q;
  logic       accept;
  logic       legal;
  logic       commit;
  logic [1:0] w1c_clr;

  assign accept = hsel_x & hready & hwrite & htrans[1];

  // Legality is judged on the latched address phase plus the live data phase.
  always_comb begin
    legal = (size_q == 3'b000);
    case (addr_q)
      2'd3: begin
        if ((hwdata[7:5] != 3'b000) || (hwdata[4:0] > DATA_SIZE_MAX)) begin
          legal = 1'b0;
        end
      end
`ifndef AHB_WRITE_W1C_EN
      2'd0: legal = 1'b0;
`endif
      default: ;
    endcase
  end

  assign commit = (state == S_DATA) && legal;

`ifdef AHB_WRITE_W1C_EN
  assign w1c_clr = (commit && (addr_q == 2'd0)) ? hwdata[1:0] : '0;
`else
  assign w1c_clr = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:         if (accept) state_nxt = S_DATA;
      S_DATA:         state_nxt = legal ? S_DONE : S_ERR1;
      S_ERR1:         state_nxt = S_ERR2;
      S_DONE, S_ERR2: state_nxt = accept ? S_DATA : S_IDLE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state      <= S_IDLE;
      hready_out <= 1'b1;
      hresp      <= 1'b0;
      wr_pulse   <= 1'b0;
      wr_addr    <= '0;
      addr_q     <= '0;
      size_q     <= '0;
    end else begin
      state      <= state_nxt;
      hready_out <= (state_nxt != S_DATA) && (state_nxt != S_ERR1);
      hresp      <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
      wr_pulse   <= commit;
      if (commit) begin
        wr_addr <= addr_q;
      end
      if (state_nxt == S_DATA) begin
        addr_q <= haddr;
        size_q <= hsize;
      end
    end
  end

  // Hardware set is ORed in after the W1C clear so a simultaneous set wins.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      err_status <= '0;
      payload_0  <= '0;
      payload_1  <= '0;
      data_size  <= '0;
    end else begin
      err_status <= (err_status & ~w1c_clr) | err_set;
      if (commit) begin
        case (addr_q)
          2'd1:    payload_0 <= hwdata;
          2'd2:    payload_1 <= hwdata;
          2'd3:    data_size <= hwdata[4:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_write_slave.sv
// Randomized self-checking bench for ahb_write_slave against a transaction-level register model.
module tb_ahb_write_slave;

  localparam int unsigned DSMAX = 16;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       hsel_x;
  logic       hready;
  logic       hwrite;
  logic [1:0] htrans;
  logic [2:0] hsize;
  logic [1:0] haddr;
  logic [7:0] hwdata;
  logic [1:0] err_set;
  logic       hready_out;
  logic       hresp;
  logic [1:0] err_status;
  logic [7:0] payload_0;
  logic [7:0] payload_1;
  logic [4:0] data_size;
  logic       wr_pulse;
  logic [1:0] wr_addr;

  ahb_write_slave #(.DATA_SIZE_MAX(5'd16)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel_x(hsel_x), .hready(hready),
    .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .haddr(haddr),
    .hwdata(hwdata), .err_set(err_set), .hready_out(hready_out), .hresp(hresp),
    .err_status(err_status), .payload_0(payload_0), .payload_1(payload_1),
    .data_size(data_size), .wr_pulse(wr_pulse), .wr_addr(wr_addr)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cyc = 0;
  bit rand_err = 1'b0;

  logic [1:0] m_err;
  logic [7:0] m_p0;
  logic [7:0] m_p1;
  logic [4:0] m_ds;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit model_legal(input logic [1:0] a, input logic [7:0] d, input logic [2:0] sz);
    if (sz != 3'b000) return 1'b0;
    if (a == 2'd3) return (int'(d) <= DSMAX);
`ifdef AHB_WRITE_W1C_EN
    return 1'b1;
`else
    return (a != 2'd0);
`endif
  endfunction

  task automatic tick(input logic [1:0] clr);
    @(posedge hclk);
    if (!hreset_n) m_err = '0;
    else m_err = (m_err & ~clr) | err_set;
    cyc++;
    #1;
    if (rand_err) err_set = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, ".err_status"}, 32'(err_status), 32'(m_err));
    check_val({tag, ".payload_0"}, 32'(payload_0), 32'(m_p0));
    check_val({tag, ".payload_1"}, 32'(payload_1), 32'(m_p1));
    check_val({tag, ".data_size"}, 32'(data_size), 32'(m_ds));
  endtask

  // Issues an address phase in the current cycle (slave must be ready) and walks the response.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic [2:0] sz);
    bit ok;
    logic [1:0] clr;
    ok = model_legal(a, d, sz);
    hsel_x = 1'b1; hready = 1'b1; hwrite = 1'b1; htrans = 2'b10; haddr = a; hsize = sz;
    tick(2'b00);
    hwdata = d; hready = 1'b0; htrans = 2'b00;
    hsel_x = 1'($urandom); hwrite = 1'($urandom); haddr = 2'($urandom); hsize = 3'($urandom);
    @(negedge hclk);
    check_val("data.hready_out", 32'(hready_out), 32'd0);
    check_val("data.hresp", 32'(hresp), 32'd0);
    check_val("data.wr_pulse", 32'(wr_pulse), 32'd0);
    clr = (ok && a == 2'd0) ? d[1:0] : 2'b00;
    tick(clr);
    if (ok) begin
      if (a == 2'd1) m_p0 = d;
      if (a == 2'd2) m_p1 = d;
      if (a == 2'd3) m_ds = d[4:0];
    end
    hwdata = 8'($urandom); hready = ok; htrans = 2'b00;
    @(negedge hclk);
    if (ok) begin
      check_val("done.hready_out", 32'(hready_out), 32'd1);
      check_val("done.hresp", 32'(hresp), 32'd0);
      check_val("done.wr_pulse", 32'(wr_pulse), 32'd1);
      check_val("done.wr_addr", 32'(wr_addr), 32'(a));
      check_regs("done");
      done_cyc = cyc;
    end else begin
      check_val("err1.hready_out", 32'(hready_out), 32'd0);
      check_val("err1.hresp", 32'(hresp), 32'd1);
      check_val("err1.wr_pulse", 32'(wr_pulse), 32'd0);
      tick(2'b00);
      hready = 1'b1;
      @(negedge hclk);
      check_val("err2.hready_out", 32'(hready_out), 32'd1);
      check_val("err2.hresp", 32'(hresp), 32'd1);
      check_val("err2.wr_pulse", 32'(wr_pulse), 32'd0);
      check_regs("err2");
      done_cyc = cyc;
    end
  endtask

  // A cycle that must not be accepted: one of the accept terms is deasserted.
  task automatic gap_cycle();
    hsel_x = 1'($urandom); hready = 1'($urandom); hwrite = 1'($urandom);
    htrans = 2'($urandom); haddr = 2'($urandom); hsize = 3'($urandom); hwdata = 8'($urandom);
    case ($urandom_range(0, 3))
      0: hsel_x = 1'b0;
      1: hwrite = 1'b0;
      2: htrans[1] = 1'b0;
      default: hready = 1'b0;
    endcase
    tick(2'b00);
    @(negedge hclk);
    check_val("gap.hready_out", 32'(hready_out), 32'd1);
    check_val("gap.hresp", 32'(hresp), 32'd0);
    check_val("gap.wr_pulse", 32'(wr_pulse), 32'd0);
    check_regs("gap");
    hready = 1'b1;
  endtask

  initial begin
    int c1;
    logic [1:0] a;
    logic [7:0] d;
    logic [2:0] sz;
    hreset_n = 1'b0; hsel_x = 1'b0; hready = 1'b1; hwrite = 1'b0; htrans = 2'b00;
    hsize = '0; haddr = '0; hwdata = '0; err_set = '0;
    m_err = '0; m_p0 = '0; m_p1 = '0; m_ds = '0;
    tick(2'b00);
    tick(2'b00);
    @(negedge hclk);
    check_val("rst.hready_out", 32'(hready_out), 32'd1);
    check_val("rst.hresp", 32'(hresp), 32'd0);
    check_val("rst.wr_pulse", 32'(wr_pulse), 32'd0);
    check_val("rst.wr_addr", 32'(wr_addr), 32'd0);
    check_regs("rst");
    hreset_n = 1'b1;
    tick(2'b00);

    do_write(2'd1, 8'hA5, 3'b000);
    check_val("dir.payload_0_a5", 32'(payload_0), 32'h0A5);
    gap_cycle();

    do_write(2'd2, 8'h3C, 3'b000);
    c1 = done_cyc;
    do_write(2'd3, 8'h0F, 3'b000);
    check_val("b2b.spacing", 32'(done_cyc - c1), 32'd2);
    check_val("b2b.payload_1", 32'(payload_1), 32'h3C);
    check_val("b2b.data_size", 32'(data_size), 32'd15);

    do_write(2'd3, 8'h11, 3'b000);
    check_val("dir.data_size_kept", 32'(data_size), 32'd15);
    do_write(2'd3, 8'h10, 3'b000);
    check_val("dir.data_size_max", 32'(data_size), 32'd16);
    do_write(2'd1, 8'h77, 3'b001);
    check_val("dir.payload_0_kept", 32'(payload_0), 32'hA5);
    gap_cycle();

    err_set = 2'b11;
    tick(2'b00);
    err_set = 2'b01;
    @(negedge hclk);
    check_val("w1c.pre", 32'(err_status), 32'd3);
    do_write(2'd0, 8'h03, 3'b000);
`ifdef AHB_WRITE_W1C_EN
    check_val("w1c.race", 32'(err_status), 32'd1);
`else
    check_val("w1c.locked", 32'(err_status), 32'd3);
`endif
    err_set = 2'b00;
    gap_cycle();

    rand_err = 1'b1;
    for (int i = 0; i < 200; i++) begin
      a = 2'($urandom);
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      sz = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      do_write(a, d, sz);
      if ($urandom_range(0, 2) == 0) gap_cycle();
    end
    rand_err = 1'b0;
    err_set = 2'b00;
    gap_cycle();

    hsel_x = 1'b1; hready = 1'b1; hwrite = 1'b1; htrans = 2'b10; haddr = 2'd1; hsize = 3'b000;
    tick(2'b00);
    hwdata = 8'hFF; htrans = 2'b00; hready = 1'b0; hreset_n = 1'b0;
    tick(2'b00);
    m_p0 = '0; m_p1 = '0; m_ds = '0;
    @(negedge hclk);
    check_val("rstdata.hready_out", 32'(hready_out), 32'd1);
    check_val("rstdata.hresp", 32'(hresp), 32'd0);
    check_val("rstdata.wr_pulse", 32'(wr_pulse), 32'd0);
    check_regs("rstdata");
    hreset_n = 1'b1; hready = 1'b1;
    tick(2'b00);
    @(negedge hclk);
    check_val("rstdata.after_pulse", 32'(wr_pulse), 32'd0);
    check_regs("rstdata.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_write_slave.md
# ahb_write_slave

AHB-Lite slave write path for the 4-entry status/payload register file: it accepts byte writes, updates `err_status`, `payload_0`, `payload_1` and `data_size`, and returns OKAY or a two-cycle ERROR. It sits beside the slave read path on the same `hsel_x` decode and supplies the register values that path returns.

## Interface
- `DATA_SIZE_MAX`, default 5'd16: largest legal `data_size`; a larger write value gets ERROR.
- `hclk` input 1: clock.
- `hreset_n` input 1: reset, synchronous, active-low.
- `hsel_x` input 1: slave select.
- `hready` input 1: bus-level ready; an address phase is valid only when it is high.
- `hwrite` input 1: 1 = write transfer.
- `htrans` input 2: transfer type; NONSEQ=2'b10, SEQ=2'b11 are active.
- `hsize` input 3: transfer size; only 3'b000 (byte) is legal.
- `haddr` input 2: register select (0 err_status, 1 payload_0, 2 payload_1, 3 data_size).
- `hwdata` input 8: write data, valid in the data phase.
- `err_set` input 2: hardware set bits for `err_status`.
- `hready_out` output 1: slave ready.
- `hresp` output 1: 1 = ERROR.
- `err_status` output 2, `payload_0` output 8, `payload_1` output 8, `data_size` output 5: register contents.
- `wr_pulse` output 1: one-cycle strobe on each committed write.
- `wr_addr` output 2: register index committed, valid with `wr_pulse`.

## Operation
- Accept an address phase when `hsel_x & hready & hwrite & htrans[1]`. Latch `haddr` and `hsize`.
- The FSM has five states:
  - IDLE: `hready_out=1`, `hresp=0`. An accepted address phase moves to DATA.
  - DATA: one fixed wait state, `hready_out=0`, `hresp=0`. Sample `hwdata` and evaluate legality.
    - Legal: commit the write, pulse `wr_pulse`, move to DONE.
    - Illegal: no register change, move to ERR1.
  - DONE: `hready_out=1`, `hresp=0`. An accepted address phase moves to DATA (back-to-back); otherwise move to IDLE.
  - ERR1: `hready_out=0`, `hresp=1`. Always moves to ERR2.
  - ERR2: `hready_out=1`, `hresp=1`. An accepted address phase moves to DATA; otherwise move to IDLE.
- A write is illegal if any of these holds:
  - the latched `hsize != 0`;
  - `haddr==3` and `hwdata[4:0] > DATA_SIZE_MAX`;
  - `haddr==3` and `hwdata[7:5] != 0`;
  - `haddr==0` and `AHB_WRITE_W1C_EN` is undefined.
- Commit rules:
  - `payload_0` and `payload_1` take all 8 bits.
  - `data_size` takes `hwdata[4:0]`.
  - `err_status` clears the bits where `hwdata[1:0]` is 1 (W1C).
- `err_status` sets bit i every cycle `err_set[i]=1`, in any state. Set wins over a simultaneous W1C clear.
- Reads, IDLE/BUSY transfers and unselected cycles do not change registers or state, except an IDLE transfer in DONE or ERR2, which moves to IDLE.

## Timing
- Reset, at an `hclk` edge with `hreset_n=0`: state IDLE, `hready_out=1`, `hresp=0`, all registers 0, `wr_pulse=0`, `wr_addr=0`. Reset during DATA, ERR1 or ERR2 aborts the transfer with no commit.
- `hready_out` and `hresp` are registered, decoded from the state register.
- Address phase sampled at edge E0: DATA during cycle E0–E1. The register updates at E1, and `wr_pulse` is high in cycle E1–E2. DONE occupies cycle E1–E2, so the master completes at E2.
- Error sequence: ERR1 in cycle E1–E2, ERR2 in cycle E2–E3, master completes at E3.
- Throughput: one write per 2 cycles back-to-back; 3 cycles for errors.

## Configuration
- `AHB_WRITE_W1C_EN` defined: `haddr==0` writes are legal and apply W1C to `err_status`.
- `AHB_WRITE_W1C_EN` undefined: `err_status` is hardware-set only and cleared only by reset. A write to `haddr==0` gets ERROR.

## Test plan
- Reset mid-DATA → next cycle IDLE, `hready_out=1`, `hresp=0`, all registers 0, no `wr_pulse`.
- Write 8'hA5 to addr 1 → `hready_out` 0 then 1 with `hresp=0`; `payload_0=8'hA5`; `wr_pulse` for one cycle with `wr_addr=1`.
- Back-to-back: 8'h3C to addr 2, then 8'h0F to addr 3, with the second address phase issued in DONE → `payload_1=8'h3C`, `data_size=5'd15`, completions 2 cycles apart.
- Write 8'h11 to addr 3 (17 > 16) → ERR1 then ERR2 (`hresp=1`, `hready_out` 0 then 1); `data_size` unchanged; no `wr_pulse`.
- Write with `hsize=3'b001` to addr 1 → ERROR, `payload_0` unchanged.
- W1C race, with the macro defined and `err_status=2'b11`: write 8'h03 to addr 0 while `err_set=2'b01` in the commit cycle → `err_status=2'b01`. With the macro undefined, the same write gets ERROR and `err_status` stays 2'b11.
